seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: one restoring step per cycle on magnitudes, then a sign fix-up.
// HI holds the remainder (sign of the dividend), LO the quotient truncated toward zero.
module seq_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Q,
    input  logic [DATA_WIDTH-1:0] M,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] m_abs_q, m_abs_d;
    logic                  q_neg_q, q_neg_d;
    logic                  quo_neg_q, quo_neg_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic                  dbz_q, dbz_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    // Shifted partial remainder needs one extra bit before the trial subtract.
    logic [DATA_WIDTH:0]   shift_rem;
    logic                  fits;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        m_abs_d   = m_abs_q;
        q_neg_d   = q_neg_q;
        quo_neg_d = quo_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        shift_rem = {rem_q, quo_q[DATA_WIDTH-1]};
        fits      = (shift_rem >= {1'b0, m_abs_q});

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (M == '0) begin
                        hi_d    = Q;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d     = Q[DATA_WIDTH-1] ? (~Q + 1'b1) : Q;
                        m_abs_d   = M[DATA_WIDTH-1] ? (~M + 1'b1) : M;
                        q_neg_d   = Q[DATA_WIDTH-1];
                        quo_neg_d = Q[DATA_WIDTH-1] ^ M[DATA_WIDTH-1];
                        rem_d     = '0;
                        cnt_d     = '0;
                        dbz_d     = 1'b0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (fits) begin
                    rem_d = DATA_WIDTH'(shift_rem - {1'b0, m_abs_q});
                    quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shift_rem[DATA_WIDTH-1:0];
                    quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = FIX;
            end
            FIX: begin
                lo_d    = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = q_neg_q ? (~rem_q + 1'b1) : rem_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d == CALC) || (state_d == FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            m_abs_q   <= '0;
            q_neg_q   <= 1'b0;
            quo_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            m_abs_q   <= m_abs_d;
            q_neg_q   <= q_neg_d;
            quo_neg_q <= quo_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule
